// File: rtl/main_control_fsm_pkg.sv
// rtl/main_control_fsm_pkg.sv - shared opcodes, state encodings and control word for the multicycle MIPS control unit
package main_control_fsm_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/main_control_fsm_outputs.sv
// rtl/main_control_fsm_outputs.sv - combinational state to control word decode
module main_control_outputs
    import main_control_fsm_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // PC+4 and IR load only commit once the fetch word is actually back
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle MIPS main control: state register, next-state logic, illegal_op flag
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    // must stay at the FETCH encoding
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d   = ST_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    default: begin
                        state_d   = ST_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = ST_MEM_READ;
                else if (opcode == OP_SW) state_d = ST_MEM_WRITE;
                else                      state_d = ST_FETCH;
            end
            ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXEC_R:    state_d = ST_R_WB;
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= state_e'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    main_control_outputs u_outputs (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // write strobes are masked during reset so an aborted instruction cannot commit
    assign PCWrite     = ctrl.pc_write      & ~reset;
    assign PCWriteCond = ctrl.pc_write_cond & ~reset;
    assign MemRead     = ctrl.mem_read      & ~reset;
    assign MemWrite    = ctrl.mem_write     & ~reset;
    assign IRWrite     = ctrl.ir_write      & ~reset;
    assign RegWrite    = ctrl.reg_write     & ~reset;
    assign IorD        = ctrl.iord;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign PCSource    = ctrl.pc_source;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUop       = ctrl.alu_op;
    assign illegal_op  = illegal_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - directed self-checking bench for main_control_fsm
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUop;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUop       (ALUop),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,PCSource,ALUSrcB,ALUop,illegal_op}
    wire [16:0] ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                       RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUop, illegal_op};

    localparam logic [16:0] C_FETCH_R   = 17'b1_0_0_1_0_0_1_0_0_0_00_01_00_0;
    localparam logic [16:0] C_FETCH_W   = 17'b0_0_0_1_0_0_0_0_0_0_00_01_00_0;
    localparam logic [16:0] C_RST_FETCH = 17'b0_0_0_0_0_0_0_0_0_0_00_01_00_0;
    localparam logic [16:0] C_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_0;
    localparam logic [16:0] C_EXEC_R    = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
    localparam logic [16:0] C_R_WB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_MEM_READ  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEM_WB    = 17'b0_0_0_0_0_1_0_1_0_0_00_00_00_0;
    localparam logic [16:0] C_MEM_WRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_RST_MEMW  = 17'b0_0_1_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_ADDI_WB   = 17'b0_0_0_0_0_0_0_1_0_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_01_00_01_0;
    localparam logic [16:0] C_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_0;
    localparam logic [16:0] C_ILL       = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3;
    localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_R_WB = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ADDI_EXEC = 4'd10, S_ADDI_WB = 4'd11;

    typedef struct {
        logic        rst;
        logic        mr;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [16:0] ctl;
    } step_t;

    function automatic step_t mk(logic rst, logic mr, logic [5:0] op, logic [3:0] st, logic [16:0] c);
        step_t s;
        s.rst = rst; s.mr = mr; s.op = op; s.st = st; s.ctl = c;
        return s;
    endfunction

    task automatic test_reset();
        step_t q[$];
        q.push_back(mk(1, 0, 6'b100011, S_FETCH, C_RST_FETCH));
        q.push_back(mk(1, 1, 6'b100011, S_FETCH, C_RST_FETCH));
        q.push_back(mk(0, 0, 6'b100011, S_FETCH, C_FETCH_W));
        foreach (q[i]) begin
            reset = q[i].rst; mem_ready = q[i].mr; opcode = q[i].op;
            #1;
            checks++;
            if (state_dbg !== q[i].st) begin
                errors++;
                $display("FAIL reset step %0d state got %0d want %0d", i, state_dbg, q[i].st);
            end
            checks++;
            if (ctl !== q[i].ctl) begin
                errors++;
                $display("FAIL reset step %0d ctl got %b want %b", i, ctl, q[i].ctl);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype_addi();
        step_t q[$];
        q.push_back(mk(0, 1, 6'b000000, S_FETCH,  C_FETCH_R));
        q.push_back(mk(0, 1, 6'b000000, S_DECODE, C_DECODE));
        q.push_back(mk(0, 1, 6'b000000, S_EXEC_R, C_EXEC_R));
        q.push_back(mk(0, 1, 6'b000000, S_R_WB,   C_R_WB));
        q.push_back(mk(0, 1, 6'b001000, S_FETCH,  C_FETCH_R));
        q.push_back(mk(0, 1, 6'b001000, S_DECODE, C_DECODE));
        q.push_back(mk(0, 1, 6'b001000, S_ADDI_EXEC, C_MEM_ADDR));
        q.push_back(mk(0, 1, 6'b001000, S_ADDI_WB, C_ADDI_WB));
        q.push_back(mk(0, 0, 6'b001000, S_FETCH,  C_FETCH_W));
        foreach (q[i]) begin
            reset = q[i].rst; mem_ready = q[i].mr; opcode = q[i].op;
            #1;
            checks++;
            if (state_dbg !== q[i].st) begin
                errors++;
                $display("FAIL rtype_addi step %0d state got %0d want %0d", i, state_dbg, q[i].st);
            end
            checks++;
            if (ctl !== q[i].ctl) begin
                errors++;
                $display("FAIL rtype_addi step %0d ctl got %b want %b", i, ctl, q[i].ctl);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        step_t q[$];
        q.push_back(mk(0, 1, 6'b100011, S_FETCH,    C_FETCH_R));
        q.push_back(mk(0, 1, 6'b100011, S_DECODE,   C_DECODE));
        q.push_back(mk(0, 0, 6'b100011, S_MEM_ADDR, C_MEM_ADDR));
        q.push_back(mk(0, 0, 6'b100011, S_MEM_READ, C_MEM_READ));
        q.push_back(mk(0, 0, 6'b100011, S_MEM_READ, C_MEM_READ));
        q.push_back(mk(0, 0, 6'b100011, S_MEM_READ, C_MEM_READ));
        q.push_back(mk(0, 1, 6'b100011, S_MEM_READ, C_MEM_READ));
        q.push_back(mk(0, 1, 6'b100011, S_MEM_WB,   C_MEM_WB));
        q.push_back(mk(0, 0, 6'b100011, S_FETCH,    C_FETCH_W));
        foreach (q[i]) begin
            reset = q[i].rst; mem_ready = q[i].mr; opcode = q[i].op;
            #1;
            checks++;
            if (state_dbg !== q[i].st) begin
                errors++;
                $display("FAIL lw_wait step %0d state got %0d want %0d", i, state_dbg, q[i].st);
            end
            checks++;
            if (ctl !== q[i].ctl) begin
                errors++;
                $display("FAIL lw_wait step %0d ctl got %b want %b", i, ctl, q[i].ctl);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_wait();
        step_t q[$];
        q.push_back(mk(0, 0, 6'b101011, S_FETCH,     C_FETCH_W));
        q.push_back(mk(0, 1, 6'b101011, S_FETCH,     C_FETCH_R));
        q.push_back(mk(0, 1, 6'b101011, S_DECODE,    C_DECODE));
        q.push_back(mk(0, 0, 6'b101011, S_MEM_ADDR,  C_MEM_ADDR));
        q.push_back(mk(0, 0, 6'b101011, S_MEM_WRITE, C_MEM_WRITE));
        q.push_back(mk(0, 0, 6'b101011, S_MEM_WRITE, C_MEM_WRITE));
        q.push_back(mk(0, 1, 6'b101011, S_MEM_WRITE, C_MEM_WRITE));
        q.push_back(mk(0, 0, 6'b101011, S_FETCH,     C_FETCH_W));
        foreach (q[i]) begin
            reset = q[i].rst; mem_ready = q[i].mr; opcode = q[i].op;
            #1;
            checks++;
            if (state_dbg !== q[i].st) begin
                errors++;
                $display("FAIL sw_wait step %0d state got %0d want %0d", i, state_dbg, q[i].st);
            end
            checks++;
            if (ctl !== q[i].ctl) begin
                errors++;
                $display("FAIL sw_wait step %0d ctl got %b want %b", i, ctl, q[i].ctl);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jump();
        step_t q[$];
        q.push_back(mk(0, 1, 6'b000100, S_FETCH,  C_FETCH_R));
        q.push_back(mk(0, 1, 6'b000100, S_DECODE, C_DECODE));
        q.push_back(mk(0, 1, 6'b000100, S_BRANCH, C_BRANCH));
        q.push_back(mk(0, 1, 6'b000010, S_FETCH,  C_FETCH_R));
        q.push_back(mk(0, 1, 6'b000010, S_DECODE, C_DECODE));
        q.push_back(mk(0, 1, 6'b000010, S_JUMP,   C_JUMP));
        q.push_back(mk(0, 0, 6'b000010, S_FETCH,  C_FETCH_W));
        foreach (q[i]) begin
            reset = q[i].rst; mem_ready = q[i].mr; opcode = q[i].op;
            #1;
            checks++;
            if (state_dbg !== q[i].st) begin
                errors++;
                $display("FAIL branch_jump step %0d state got %0d want %0d", i, state_dbg, q[i].st);
            end
            checks++;
            if (ctl !== q[i].ctl) begin
                errors++;
                $display("FAIL branch_jump step %0d ctl got %b want %b", i, ctl, q[i].ctl);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_and_abort();
        step_t q[$];
        q.push_back(mk(0, 1, 6'b111111, S_FETCH,     C_FETCH_R));
        q.push_back(mk(0, 1, 6'b111111, S_DECODE,    C_DECODE));
        q.push_back(mk(0, 1, 6'b111111, S_FETCH,     C_FETCH_R | C_ILL));
        q.push_back(mk(0, 0, 6'b111111, S_DECODE,    C_DECODE));
        q.push_back(mk(0, 0, 6'b111111, S_FETCH,     C_FETCH_W | C_ILL));
        q.push_back(mk(0, 1, 6'b101011, S_FETCH,     C_FETCH_R));
        q.push_back(mk(0, 1, 6'b101011, S_DECODE,    C_DECODE));
        q.push_back(mk(0, 0, 6'b101011, S_MEM_ADDR,  C_MEM_ADDR));
        q.push_back(mk(0, 0, 6'b101011, S_MEM_WRITE, C_MEM_WRITE));
        q.push_back(mk(1, 0, 6'b101011, S_MEM_WRITE, C_RST_MEMW));
        q.push_back(mk(1, 1, 6'b101011, S_FETCH,     C_RST_FETCH));
        q.push_back(mk(0, 0, 6'b101011, S_FETCH,     C_FETCH_W));
        foreach (q[i]) begin
            reset = q[i].rst; mem_ready = q[i].mr; opcode = q[i].op;
            #1;
            checks++;
            if (state_dbg !== q[i].st) begin
                errors++;
                $display("FAIL illegal_abort step %0d state got %0d want %0d", i, state_dbg, q[i].st);
            end
            checks++;
            if (ctl !== q[i].ctl) begin
                errors++;
                $display("FAIL illegal_abort step %0d ctl got %b want %b", i, ctl, q[i].ctl);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'b100011;
        @(negedge clk);
        test_reset();
        test_rtype_addi();
        test_lw_wait();
        test_sw_wait();
        test_branch_jump();
        test_illegal_and_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
